// File: rtl/apb_gpio_irq.sv
// APB GPIO peripheral with synchronized inputs, per-pin edge detection and a level interrupt.
// Optional input debounce filter enabled by defining ZH_GPIO_DEBOUNCE_EN.
module apb_gpio_irq #(
  parameter int unsigned NrGpio       = 32,
  parameter int unsigned ApbAddrWidth = 32,
  parameter int unsigned SyncStages   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [ApbAddrWidth-1:0] paddr_i,
  input  logic [31:0]             pwdata_i,
  output logic [31:0]             prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  input  logic [NrGpio-1:0]       gpio_i,
  output logic [NrGpio-1:0]       gpio_o,
  output logic [NrGpio-1:0]       gpio_oe_o,
  output logic                    irq_o
);

  localparam logic [3:0] RegDir      = 4'd0;
  localparam logic [3:0] RegOut      = 4'd1;
  localparam logic [3:0] RegIn       = 4'd2;
  localparam logic [3:0] RegIrqEn    = 4'd3;
  localparam logic [3:0] RegRiseEn   = 4'd4;
  localparam logic [3:0] RegFallEn   = 4'd5;
  localparam logic [3:0] RegPend     = 4'd6;
  localparam logic [3:0] RegOutSet   = 4'd7;
  localparam logic [3:0] RegOutClr   = 4'd8;
  localparam logic [3:0] RegDebounce = 4'd9;

  logic [3:0]        addr;
  logic              mapped;
  logic              access;
  logic              wr_en;
  logic [NrGpio-1:0] wdata;

  logic [NrGpio-1:0] dir_q, out_q, irq_en_q, rise_en_q, fall_en_q, pend_q;
  logic [NrGpio-1:0] pend_d, w1c_mask, edge_set;
  logic [NrGpio-1:0] in_val, hist_q;
  logic [SyncStages-1:0][NrGpio-1:0] sync_q;
  logic [NrGpio-1:0] sync_val;

  // Only paddr_i[5:2] is decoded and pwdata_i is truncated to NrGpio bits.
  logic unused_bits;
  assign unused_bits = ^{paddr_i, pwdata_i};

  assign addr     = paddr_i[5:2];
  assign access   = psel_i & penable_i;
  assign wdata    = pwdata_i[NrGpio-1:0];
  assign pready_o = 1'b1;

`ifdef ZH_GPIO_DEBOUNCE_EN
  assign mapped = (addr <= RegDebounce);
`else
  assign mapped = (addr <= RegOutClr);
`endif

  assign wr_en     = access & pwrite_i & mapped;
  assign pslverr_o = access & ~mapped;

  // Input synchronizer: stage 0 samples the pad, the last stage feeds the logic.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      sync_q <= '0;
    end else begin
      // NOTE: flops use non-blocking assignments so every stage samples the pre-edge value of its predecessor.
      sync_q <= {sync_q[SyncStages-2:0], gpio_i};
    end
  end
  assign sync_val = sync_q[SyncStages-1];

`ifdef ZH_GPIO_DEBOUNCE_EN
  logic [15:0]       deb_q;
  logic [NrGpio-1:0] filt_q;
  logic [15:0]       cnt_q [NrGpio];

  // Filtered value follows the synchronizer only after DEBOUNCE+1 consecutive mismatching cycles.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      filt_q <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so resetting it is cheap and avoids X.
      for (int i = 0; i < NrGpio; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NrGpio; i++) begin
        if (sync_val[i] != filt_q[i]) begin
          if (cnt_q[i] == deb_q) begin
            filt_q[i] <= sync_val[i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 16'd1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      deb_q <= '0;
    end else if (wr_en && addr == RegDebounce) begin
      deb_q <= pwdata_i[15:0];
    end
  end

  assign in_val = filt_q;
`else
  assign in_val = sync_val;
`endif

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) hist_q <= '0;
    else        hist_q <= in_val;
  end

  assign edge_set = (in_val & ~hist_q & rise_en_q) | (~in_val & hist_q & fall_en_q);
  assign w1c_mask = (wr_en && addr == RegPend) ? wdata : '0;
  // A new edge overrides a simultaneous clear of the same bit.
  assign pend_d   = (pend_q & ~w1c_mask) | edge_set;

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      dir_q     <= '0;
      out_q     <= '0;
      irq_en_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
    end else begin
      pend_q <= pend_d;
      if (wr_en) begin
        case (addr)
          RegDir:    dir_q     <= wdata;
          RegOut:    out_q     <= wdata;
          RegIrqEn:  irq_en_q  <= wdata;
          RegRiseEn: rise_en_q <= wdata;
          RegFallEn: fall_en_q <= wdata;
          RegOutSet: out_q     <= out_q | wdata;
          RegOutClr: out_q     <= out_q & ~wdata;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves prdata_o unassigned (no latch).
    prdata_o = '0;
    if (psel_i && mapped) begin
      case (addr)
        RegDir:      prdata_o = 32'(dir_q);
        RegOut:      prdata_o = 32'(out_q);
        RegIn:       prdata_o = 32'(in_val);
        RegIrqEn:    prdata_o = 32'(irq_en_q);
        RegRiseEn:   prdata_o = 32'(rise_en_q);
        RegFallEn:   prdata_o = 32'(fall_en_q);
        RegPend:     prdata_o = 32'(pend_q);
`ifdef ZH_GPIO_DEBOUNCE_EN
        RegDebounce: prdata_o = 32'(deb_q);
`endif
        default:     prdata_o = '0;
      endcase
    end
  end

  assign gpio_o    = out_q;
  assign gpio_oe_o = dir_q;
  assign irq_o     = |(pend_q & irq_en_q);

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Directed testbench for apb_gpio_irq: register map, edge timing, interrupt and W1C races.
module tb_apb_gpio_irq;

  localparam int NrGpio = 32;
`ifdef ZH_GPIO_DEBOUNCE_EN
  localparam int Lat = 3;
  localparam int FirstUnmapped = 32'h28;
`else
  localparam int Lat = 2;
  localparam int FirstUnmapped = 32'h24;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [NrGpio-1:0] gpio = '0;
  logic [NrGpio-1:0] gpio_o, gpio_oe;
  logic        irq;

  int checks = 0;
  int errors = 0;

  apb_gpio_irq #(.NrGpio(NrGpio), .ApbAddrWidth(32), .SyncStages(2)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .psel_i    (psel),
    .penable_i (penable),
    .pwrite_i  (pwrite),
    .paddr_i   (paddr),
    .pwdata_i  (pwdata),
    .prdata_o  (prdata),
    .pready_o  (pready),
    .pslverr_o (pslverr),
    .gpio_i    (gpio),
    .gpio_o    (gpio_o),
    .gpio_oe_o (gpio_oe),
    .irq_o     (irq)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk_i); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(posedge clk_i); #1;
    penable = 1'b1;
    @(posedge clk_i); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
    @(posedge clk_i); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(posedge clk_i); #1;
    penable = 1'b1;
    #3;
    data = prdata;
    err  = pslverr;
    @(posedge clk_i); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_read(addr, d, e);
    check(tag, d, exp);
    check({tag, "_err"}, {31'd0, e}, 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    check("rst_oe", gpio_oe, 32'h0);
    check("rst_out", gpio_o, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_prdata", prdata, 32'h0);
    check("rst_pslverr", {31'd0, pslverr}, 32'h0);
    check("pready", {31'd0, pready}, 32'h1);
    for (int a = 0; a <= 32'h20; a += 4) read_check($sformatf("rst_rd_%02h", a), a, 32'h0);
    for (int a = FirstUnmapped; a <= 32'h3C; a += 4) begin
      apb_read(a, d, e);
      check($sformatf("unmap_err_%02h", a), {31'd0, e}, 32'h1);
      check($sformatf("unmap_data_%02h", a), d, 32'h0);
    end

    // DIR / OUT / OUT_SET / OUT_CLR
    apb_write(32'h00, 32'h0000_00FF);
    apb_write(32'h04, 32'h0000_00A5);
    check("oe_ff", gpio_oe, 32'h0000_00FF);
    check("out_a5", gpio_o, 32'h0000_00A5);
    apb_write(32'h1C, 32'h0000_0100);
    apb_write(32'h20, 32'h0000_0001);
    read_check("out_rmw", 32'h04, 32'h0000_01A4);
    check("gpio_o_rmw", gpio_o, 32'h0000_01A4);
    read_check("outset_rd", 32'h1C, 32'h0);
    read_check("outclr_rd", 32'h20, 32'h0);
    apb_write(32'h30, 32'hFFFF_FFFF);
    read_check("dir_after_unmap_wr", 32'h00, 32'h0000_00FF);
    apb_write(32'h08, 32'hFFFF_FFFF);
    read_check("in_wr_ignored", 32'h08, 32'h0);

    // Rising edge timing on pin 0
    apb_write(32'h10, 32'h1);
    apb_write(32'h0C, 32'h1);
    @(posedge clk_i); #1;
    gpio[0] = 1'b1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h08;
    for (int k = 1; k <= Lat; k++) begin
      @(posedge clk_i); #1;
      check($sformatf("in_T+%0d", k), prdata, (k == Lat) ? 32'h1 : 32'h0);
      check($sformatf("irq_T+%0d", k), {31'd0, irq}, 32'h0);
    end
    @(posedge clk_i); #1;
    check("irq_rise", {31'd0, irq}, 32'h1);
    psel = 1'b0;
    read_check("pend_rise", 32'h18, 32'h1);
    apb_write(32'h18, 32'h1);
    check("irq_w1c", {31'd0, irq}, 32'h0);
    read_check("pend_w1c", 32'h18, 32'h0);

    // Falling edge on pin 3 with IRQ masked, then enabled
    apb_write(32'h0C, 32'h0);
    apb_write(32'h14, 32'h8);
    gpio[3] = 1'b1;
    repeat (6) @(posedge clk_i);
    #1 gpio[3] = 1'b0;
    repeat (6) @(posedge clk_i);
    read_check("pend_fall", 32'h18, 32'h8);
    check("irq_masked", {31'd0, irq}, 32'h0);
    apb_write(32'h0C, 32'h8);
    check("irq_unmask", {31'd0, irq}, 32'h1);

    // Set-wins race on pin 0
    apb_write(32'h18, 32'h8);
    check("irq_clr3", {31'd0, irq}, 32'h0);
    apb_write(32'h0C, 32'h1);
    #1 gpio[0] = 1'b0;
    repeat (6) @(posedge clk_i);
    #1 gpio[0] = 1'b1;
    repeat (6) @(posedge clk_i);
    read_check("pend_pre_race", 32'h18, 32'h1);
    apb_write(32'h18, 32'h0);
    read_check("pend_w0_keep", 32'h18, 32'h1);
    #1 gpio[0] = 1'b0;
    repeat (6) @(posedge clk_i);
    #1 gpio[0] = 1'b1;
    repeat (Lat - 1) @(posedge clk_i);
    #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h18; pwdata = 32'h1;
    @(posedge clk_i); #1;
    penable = 1'b1;
    @(posedge clk_i); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    check("irq_race", {31'd0, irq}, 32'h1);
    read_check("pend_race", 32'h18, 32'h1);
    apb_write(32'h18, 32'h1);
    read_check("pend_final_clr", 32'h18, 32'h0);

`ifdef ZH_GPIO_DEBOUNCE_EN
    // Debounce filter on pin 1
    apb_write(32'h24, 32'h4);
    read_check("deb_rd", 32'h24, 32'h4);
    apb_write(32'h10, 32'h2);
    #1 gpio[1] = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 gpio[1] = 1'b0;
    repeat (12) @(posedge clk_i);
    read_check("deb_short_in", 32'h08, 32'h1);
    read_check("deb_short_pend", 32'h18, 32'h0);
    @(posedge clk_i); #1;
    gpio[1] = 1'b1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h08;
    repeat (6) @(posedge clk_i);
    #1 check("deb_T+6", prdata, 32'h1);
    @(posedge clk_i); #1;
    check("deb_T+7", prdata, 32'h3);
    psel = 1'b0;
    repeat (4) @(posedge clk_i);
    #1 gpio[1] = 1'b0;
`endif

    // Reset asserted during an access phase aborts the write
    @(posedge clk_i); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'h55;
    @(posedge clk_i); #1;
    penable = 1'b1;
    #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    rst_ni = 1'b0;
    check("midrst_oe", gpio_oe, 32'h0);
    check("midrst_out", gpio_o, 32'h0);
    check("midrst_irq", {31'd0, irq}, 32'h0);
    read_check("midrst_dir", 32'h00, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_gpio_irq.md
Name: apb_gpio_irq

Overview:
- APB-slave GPIO peripheral that occupies a port of the top-level APB demux, alongside the UART, mtimer and I2C slaves.
- Drives and samples up to NrGpio pins.
- Detects rising and falling edges on input pins, latches them into pending bits, and produces one level interrupt for the core's external IRQ vector.
- Zero-wait-state slave: pready is tied high.

Parameters:
- NrGpio, 32: number of GPIO pins, 1..32.
- ApbAddrWidth, 32: width of paddr_i.
- SyncStages, 2: input synchronizer depth, minimum 2.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset: asynchronous, active-high (asserted when 1).
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- pwrite_i  in  1  APB write.
- paddr_i  in  ApbAddrWidth  APB address; only bits [5:2] are decoded.
- pwdata_i  in  32  APB write data.
- prdata_o  out  32  APB read data.
- pready_o  out  1  APB ready; constant 1.
- pslverr_o  out  1  APB error.
- gpio_i  in  NrGpio  asynchronous pad inputs.
- gpio_o  out  NrGpio  pad output values.
- gpio_oe_o  out  NrGpio  pad output enables; 1 = drive.
- irq_o  out  1  level interrupt to the core.

Behaviour:
- Access condition: a transfer happens when psel_i & penable_i are both 1. Writes take effect on the clock edge that ends the access phase.
- Register map, offsets in bytes. Bits at or above NrGpio read 0 and ignore writes.
  - 0x00 DIR: RW, 1 = output; drives gpio_oe_o.
  - 0x04 OUT: RW; drives gpio_o.
  - 0x08 IN: RO; synchronized input value.
  - 0x0C IRQ_EN: RW.
  - 0x10 RISE_EN: RW.
  - 0x14 FALL_EN: RW.
  - 0x18 PEND: read; write-1-to-clear.
  - 0x1C OUT_SET: WO; OUT |= pwdata. Reads 0.
  - 0x20 OUT_CLR: WO; OUT &= ~pwdata. Reads 0.
- Unmapped offsets (0x24..0x3C):
  - pslverr_o = 1 during the access phase, prdata_o = 0, no state change.
  - pslverr_o is 0 otherwise.
- Read path: prdata_o is combinational from the register file while psel_i is 1, and 0 when psel_i is 0.
- Writes to IN are ignored without error.
- Reset (rst_ni = 1):
  - All registers, synchronizer flops and edge-history flops clear to 0.
  - gpio_o = 0, gpio_oe_o = 0, irq_o = 0, prdata_o = 0, pslverr_o = 0.
  - Reset mid-transfer aborts the transfer with no register update.
- Input path:
  - gpio_i passes through a SyncStages-flop synchronizer, then one history flop.
  - IN shows the synchronizer output, so a pad change is visible SyncStages cycles later.
- Edge detection, per bit:
  - rise = sync & ~hist; fall = ~sync & hist.
  - PEND[i] is set on (rise & RISE_EN) | (fall & FALL_EN).
  - A pad change sets PEND at cycle SyncStages+1 after the change.
  - Edge detection runs regardless of DIR, so output loopback is visible.
- Interrupt: irq_o = |(PEND & IRQ_EN), driven combinationally from registers. It rises in the same cycle PEND is set.
- PEND write behaviour:
  - Set wins: a W1C on bit i in the same cycle a new edge on bit i is detected leaves PEND[i] = 1.
  - Writing 0 bits leaves PEND unchanged.
- IRQ_EN gates irq_o only, not PEND latching. Enabling IRQ_EN with PEND already set asserts irq_o on the next cycle.
- OUT_SET and OUT_CLR are atomic single-cycle read-modify-writes; no read is required.

Optional Feature:
- Macro: ZH_GPIO_DEBOUNCE_EN.
- When defined:
  - Adds register 0x24 DEBOUNCE (RW, 16 bit, reset 0).
  - Each pin gets a debounce counter after the synchronizer. The filtered value updates only after the synchronized value differs from it for DEBOUNCE+1 consecutive cycles.
  - A mismatch of fewer cycles resets that pin's counter to 0.
  - DEBOUNCE = 0 gives 1 extra cycle of latency.
  - IN and edge detection use the filtered value.
  - Offset 0x24 is then mapped and returns no pslverr.
- When undefined:
  - No counters and no extra latency.
  - 0x24 is unmapped and returns pslverr.

Test Plan:
- Reset, then read all offsets 0x00..0x20 → all return 0; reads of 0x24..0x3C return pslverr = 1 with the macro off; gpio_oe_o = 0, irq_o = 0.
- Write DIR = 0x0000_00FF, OUT = 0xA5 → gpio_oe_o = 0xFF, gpio_o = 0xA5. Then OUT_SET 0x100 and OUT_CLR 0x01 → OUT reads 0x1A4.
- Set RISE_EN = 0x1 and IRQ_EN = 0x1, raise gpio_i[0] at cycle T → IN[0] = 1 at T+2, PEND = 0x1 and irq_o = 1 at T+3. W1C PEND with 0x1 → irq_o = 0 the next cycle.
- FALL_EN[3] = 1, IRQ_EN = 0, falling edge on pin 3 → PEND = 0x8 and irq_o = 0. Write IRQ_EN = 0x8 → irq_o = 1.
- W1C PEND[0] in the same cycle a qualifying rise is detected on pin 0 → PEND[0] stays 1 and irq_o stays 1.
- With ZH_GPIO_DEBOUNCE_EN and DEBOUNCE = 4: a 3-cycle pulse on gpio_i[1] → IN stays 0 and no PEND. A 10-cycle pulse → IN[1] = 1 after 2+5 cycles.
